// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: keeps the fetch PC, issues one memory request at a time and
// buffers returned instructions in a small queue toward ID; redirects flush and discard.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t           state;
  logic [31:0]      pc;
  entry_t           q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             enq_c;
  logic             deq_c;
  logic [CNT_W-1:0] count_after_c;
  logic [31:0]      target_pc_c;
  logic [31:0]      pc_inc_c;

  // Queue traffic is suppressed on a redirect edge; the flush wins.
  assign enq_c         = (state == REQ) && inst_resp && !redirect;
  assign deq_c         = id_valid && id_ready && !redirect;
  assign count_after_c = count + CNT_W'(enq_c) - CNT_W'(deq_c);
  assign target_pc_c   = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc_c      = pc + 32'd4;

  assign id_valid = (count != '0);
  assign id_pc    = q[rd_ptr].pc;
  assign id_instr = q[rd_ptr].instr;

  // Fetch FSM, PC and queue storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      inst_read <= 1'b0;
      inst_addr <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        q[i] <= '0;
      end
    end else if (redirect) begin
      pc     <= target_pc_c;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // An unanswered request must still be drained; address stays on the bus.
      if ((state == REQ || state == DISCARD) && !inst_resp) begin
        state     <= DISCARD;
        inst_read <= 1'b1;
      end else begin
        state     <= REQ;
        inst_read <= 1'b1;
        inst_addr <= target_pc_c;
      end
    end else begin
      if (enq_c) begin
        q[wr_ptr].pc    <= pc;
        q[wr_ptr].instr <= inst_rdata;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (deq_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_after_c;

      case (state)
        IDLE: begin
          state     <= REQ;
          inst_read <= 1'b1;
          inst_addr <= pc;
        end
        REQ: begin
          if (inst_resp) begin
            pc <= pc_inc_c;
            if (count_after_c < CNT_W'(QDEPTH)) begin
              state     <= REQ;
              inst_read <= 1'b1;
              inst_addr <= pc_inc_c;
            end else begin
              state     <= HOLD;
              inst_read <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (deq_c) begin
            state     <= REQ;
            inst_read <= 1'b1;
            inst_addr <= pc;
          end
        end
        DISCARD: begin
          if (inst_resp) begin
            state     <= REQ;
            inst_read <= 1'b1;
            inst_addr <= pc;
          end
        end
        default: begin
          state     <= IDLE;
          inst_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable memory, queue-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch_unit;

  localparam int unsigned QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .inst_read  (inst_read),
    .inst_addr  (inst_addr),
    .inst_resp  (inst_resp),
    .inst_rdata (inst_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory: accepts a request when idle, answers mem_lat cycles later for one cycle.
  int          mem_lat = 1;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] req_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
      mem_addr   <= '0;
      inst_resp  <= 1'b0;
      inst_rdata <= '0;
    end else if (inst_resp) begin
      inst_resp  <= 1'b0;
      inst_rdata <= $urandom;
    end else if (mem_busy) begin
      if (mem_cnt == 0) begin
        inst_resp  <= 1'b1;
        inst_rdata <= mem_word(mem_addr);
        mem_busy   <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end else if (inst_read) begin
      req_log.push_back(inst_addr);
      mem_addr <= inst_addr;
      if (mem_lat <= 1) begin
        inst_resp  <= 1'b1;
        inst_rdata <= mem_word(inst_addr);
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_lat - 2;
      end
    end
  end

  // Reference model: a queue of {pc, instr}, the next fetch PC and the outstanding request.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_started;
  bit          m_out;
  bit          m_disc;

  initial begin
    bit deq;
    m_pc = RESET_PC; m_addr = '0; m_started = 0; m_out = 0; m_disc = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_q.delete();
        m_pc = RESET_PC; m_addr = '0; m_started = 0; m_out = 0; m_disc = 0;
      end else begin
        deq = (m_q.size() != 0) && id_ready;
        m_started = 1;
        if (redirect) begin
          m_q.delete();
          m_pc = redirect_pc & 32'hFFFF_FFFC;
          if (m_out && !inst_resp) begin
            m_disc = 1;
          end else begin
            m_out = 1; m_disc = 0; m_addr = m_pc;
          end
        end else if (!m_out) begin
          if (deq) void'(m_q.pop_front());
          if (m_q.size() < QDEPTH) begin
            m_out = 1; m_addr = m_pc;
          end
        end else if (inst_resp) begin
          if (deq) void'(m_q.pop_front());
          if (!m_disc) begin
            m_q.push_back({m_addr, inst_rdata});
            m_pc = m_addr + 32'd4;
          end
          m_disc = 0;
          m_out  = (m_q.size() < QDEPTH);
          m_addr = m_pc;
        end else begin
          if (deq) void'(m_q.pop_front());
        end
      end
    end
  end

  // Log of entries actually handed to ID.
  logic [63:0] deq_log[$];
  initial forever begin
    @(posedge clk);
    if (rst_n && id_valid && id_ready && !redirect) deq_log.push_back({id_pc, id_instr});
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check32("inst_read", 32'(inst_read), 32'(m_out));
      if (m_out) check32("inst_addr", inst_addr, m_addr);
      check32("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check32("id_pc", id_pc, m_q[0][63:32]);
        check32("id_instr", id_instr, m_q[0][31:0]);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_log.delete();
    deq_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input int n, input string name);
    int b = 0;
    while (req_log.size() < n && b < 400) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (req_log.size() < n) timeout_fail(name);
  endtask

  initial begin
    int b;
    int k;
    int n68;

    // Reset state and in-order fetch with 1-cycle memory.
    id_ready = 1'b1;
    mem_lat  = 1;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_inst_read", 32'(inst_read), 32'd0);
    check32("rst_id_valid", 32'(id_valid), 32'd0);
    check32("rst_id_pc", id_pc, 32'd0);
    check32("rst_id_instr", id_instr, 32'd0);
    rst_n = 1'b1;
    wait_req(4, "p1_requests");
    repeat (4) @(posedge clk);
    #1;
    check32("p1_addr0", req_log[0], 32'h0000_0060);
    check32("p1_addr1", req_log[1], 32'h0000_0064);
    check32("p1_addr2", req_log[2], 32'h0000_0068);
    check32("p1_deq0_pc", deq_log[0][63:32], 32'h0000_0060);
    check32("p1_deq0_instr", deq_log[0][31:0], 32'hFF9F_0060);
    check32("p1_deq2_pc", deq_log[2][63:32], 32'h0000_0068);
    check32("p1_deq2_instr", deq_log[2][31:0], 32'hFF97_0068);

    // ID stalled, 3-cycle memory: queue fills, fetch holds, then drains and resumes.
    id_ready = 1'b0;
    mem_lat  = 3;
    apply_reset();
    repeat (30) @(posedge clk);
    #1;
    check32("p2_nreq", req_log.size(), 32'd2);
    check32("p2_hold_read", 32'(inst_read), 32'd0);
    check32("p2_head_pc", id_pc, 32'h0000_0060);
    id_ready = 1'b1;
    wait_req(3, "p2_resume");
    repeat (6) @(posedge clk);
    #1;
    check32("p2_addr2", req_log[2], 32'h0000_0068);
    check32("p2_deq0_pc", deq_log[0][63:32], 32'h0000_0060);
    check32("p2_deq1_pc", deq_log[1][63:32], 32'h0000_0064);
    check32("p2_deq1_instr", deq_log[1][31:0], 32'hFF9B_0064);

    // Redirect while the 0x68 request is outstanding.
    apply_reset();
    b = 0;
    do begin
      @(posedge clk); #1; b++;
    end while (!(inst_read && inst_addr == 32'h68) && b < 200);
    if (b >= 200) timeout_fail("p3_find_0x68");
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(posedge clk); #1;
    redirect = 1'b0;
    check32("p3_read_held", 32'(inst_read), 32'd1);
    check32("p3_addr_held", inst_addr, 32'h0000_0068);
    check32("p3_flushed", 32'(id_valid), 32'd0);
    b = 0;
    while (!id_valid && b < 200) begin
      @(posedge clk); #1; b++;
    end
    if (!id_valid) timeout_fail("p3_wait_0x200");
    check32("p3_head_pc", id_pc, 32'h0000_0200);
    check32("p3_req_after", req_log[3], 32'h0000_0200);
    n68 = 0;
    foreach (deq_log[i]) if (deq_log[i][63:32] == 32'h68) n68++;
    check32("p3_no_stale", n68, 32'd0);

    // Redirect in the same cycle as a response: response dropped, PC aligned.
    mem_lat = 2;
    b = 0;
    do begin
      @(posedge clk); #1; b++;
    end while (!inst_resp && b < 200);
    if (!inst_resp) timeout_fail("p4_wait_resp");
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(posedge clk); #1;
    redirect = 1'b0;
    check32("p4_read", 32'(inst_read), 32'd1);
    check32("p4_addr", inst_addr, 32'h0000_0100);
    check32("p4_empty", 32'(id_valid), 32'd0);

    // PC wrap at the top of the address space.
    repeat (3) @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect = 1'b0;
    k = -1;
    b = 0;
    while (b < 200 && !(k >= 0 && req_log.size() > k + 1)) begin
      @(posedge clk); #1; b++;
      if (k < 0) foreach (req_log[i]) if (k < 0 && req_log[i] == 32'hFFFF_FFFC) k = i;
    end
    if (k < 0 || req_log.size() <= k + 1) timeout_fail("p6_wrap");
    else check32("p6_wrap_addr", req_log[k+1], 32'h0000_0000);

    // Asynchronous reset with an entry queued and a request pending.
    id_ready = 1'b0;
    mem_lat  = 3;
    b = 0;
    do begin
      @(posedge clk); #1; b++;
    end while (!(id_valid && inst_read) && b < 200);
    if (b >= 200) timeout_fail("p5_wait_busy");
    rst_n = 1'b0;
    #1;
    check32("p5_async_valid", 32'(id_valid), 32'd0);
    check32("p5_async_read", 32'(inst_read), 32'd0);
    check32("p5_async_pc", id_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req_log.delete();
    deq_log.delete();
    id_ready = 1'b1;
    rst_n = 1'b1;
    wait_req(1, "p5_restart");
    check32("p5_first_addr", req_log[0], 32'h0000_0060);

    // Randomized traffic checked by the per-cycle model.
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      id_ready    = ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mem_lat     = $urandom_range(1, 4);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
    end
    @(posedge clk); #2;
    redirect = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
